// File: rtl/ad9228_capture_buffer.sv
// Triggered pre/post-window capture of AD9228 sample words with valid/ready readout.
// Define CAPTURE_TIMESTAMP_EN to prefix each window with a 48-bit trigger timestamp word.
module ad9228_capture_buffer #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned CH    = 4,
  parameter int unsigned SW    = 12,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic               aclk,
  input  logic               rst,
  input  logic [CH*SW-1:0]   s_data,
  input  logic               s_valid,
  input  logic               arm,
  input  logic               trig_in,
  input  logic [AW-1:0]      pre_samples,
  output logic [CH*SW-1:0]   m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
  output logic               busy,
  output logic               done,
  output logic [2:0]         state
);

  localparam int unsigned DW = CH * SW;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_READ = 3'd4
  } state_e;

  state_e          state_q;
  logic            trig_q;
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q, start_ptr_q, pre_len_q, fill_cnt_q;
  logic [CW-1:0]   post_cnt_q, rd_cnt_q;
  logic            s1_valid_q, s1_last_q, s1_hdr_q, hdr_pend_q;
  logic [DW-1:0]   ram_rd_q, m_data_q;
  logic            m_valid_q, m_last_q, busy_q, done_q;
  logic [DW-1:0]   mem [DEPTH];

  logic            trig_edge, wr_en, advance, rd_en;
  logic [AW-1:0]   pre_len_d, fill_cnt_d, start_ptr_d;
  logic [CW-1:0]   post_rem_d;
  logic [DW-1:0]   hdr_word;

  always_comb begin
    trig_edge   = trig_in & ~trig_q;
    wr_en       = s_valid && (state_q == S_FILL || state_q == S_WAIT || state_q == S_POST);
    advance     = !m_valid_q || m_ready;
    rd_en       = (state_q == S_READ) && advance && !hdr_pend_q && (rd_cnt_q != CW'(DEPTH));
    pre_len_d   = (pre_samples > AW'(DEPTH - 1)) ? AW'(DEPTH - 1) : pre_samples;
    fill_cnt_d  = fill_cnt_q + AW'(s_valid);
    start_ptr_d = wr_ptr_q - pre_len_q;
    // The edge-cycle sample, if valid, already counts as the first post sample.
    post_rem_d  = CW'(DEPTH) - CW'(pre_len_q) - CW'(s_valid);
  end

`ifdef CAPTURE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
  logic [47:0] ts_cnt_q, ts_lat_q;

  always_ff @(posedge aclk) begin
    if (rst) begin
      ts_cnt_q <= '0;
      ts_lat_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 48'd1;
      if (state_q == S_WAIT && trig_edge) ts_lat_q <= ts_cnt_q;
    end
  end

  assign hdr_word = DW'(ts_lat_q);
`else
  localparam bit TS_EN = 1'b0;
  assign hdr_word = '0;
`endif

  // History RAM: simple dual port, registered read.
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr_q] <= s_data;
    if (rd_en) ram_rd_q <= mem[rd_ptr_q];
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      trig_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      start_ptr_q <= '0;
      pre_len_q   <= '0;
      fill_cnt_q  <= '0;
      post_cnt_q  <= '0;
      rd_cnt_q    <= '0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_hdr_q    <= 1'b0;
      hdr_pend_q  <= 1'b0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      trig_q <= trig_in;
      done_q <= 1'b0;
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);

      case (state_q)
        S_IDLE: begin
          if (arm) begin
            pre_len_q  <= pre_len_d;
            fill_cnt_q <= '0;
            rd_cnt_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_hdr_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            hdr_pend_q <= TS_EN;
            busy_q     <= 1'b1;
            state_q    <= (pre_len_d == '0) ? S_WAIT : S_FILL;
          end
        end
        S_FILL: begin
          fill_cnt_q <= fill_cnt_d;
          if (fill_cnt_d == pre_len_q) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (trig_edge) begin
            start_ptr_q <= start_ptr_d;
            post_cnt_q  <= post_rem_d;
            if (post_rem_d == '0) begin
              rd_ptr_q <= start_ptr_d;
              state_q  <= S_READ;
            end else begin
              state_q  <= S_POST;
            end
          end
        end
        S_POST: begin
          if (s_valid) begin
            post_cnt_q <= post_cnt_q - CW'(1);
            if (post_cnt_q == CW'(1)) begin
              rd_ptr_q <= start_ptr_q;
              state_q  <= S_READ;
            end
          end
        end
        S_READ: begin
          // Two-stage pipe (RAM read register, output register) stalled as one.
          if (advance) begin
            m_valid_q <= s1_valid_q;
            m_last_q  <= s1_last_q;
            if (s1_valid_q) m_data_q <= s1_hdr_q ? hdr_word : ram_rd_q;
            s1_valid_q <= 1'b0;
            s1_hdr_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            if (hdr_pend_q) begin
              s1_valid_q <= 1'b1;
              s1_hdr_q   <= 1'b1;
              hdr_pend_q <= 1'b0;
            end else if (rd_en) begin
              s1_valid_q <= 1'b1;
              s1_last_q  <= (rd_cnt_q == CW'(DEPTH - 1));
              rd_ptr_q   <= rd_ptr_q + AW'(1);
              rd_cnt_q   <= rd_cnt_q + CW'(1);
            end
          end
          if (m_valid_q && m_ready && m_last_q) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign state   = state_q;

endmodule
